// File: rtl/act_bin_buffer.sv
// act_bin_buffer: binarized activation frame buffer.
//
// Captures one pooled pixel per cycle from each of the 6 conv/pool channels and
// binarizes it (bit = din > THRESH, signed). It stores one complete frame per
// channel and replays the frame once, on request, as signed +1/-1 words paced by
// din_ready.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   state                layer select (0: N_L0 pixels, 1: N_L1), sampled on leaving IDLE
//   ivalid[5:0]          per-channel valid; only all-ones is a write
//   din_0..din_5         signed pooled pixels
//   rd_start             replay request, honoured only while full
//   din_ready            consumer ready; one word is issued per ready cycle in DRAIN
//   dout_0..dout_5       replayed activation words (+1 / -1), 0 after reset
//   ovalid               dout_* valid this cycle
//   full, busy, err      status: frame held / FILL or DRAIN / sticky error
module act_bin_buffer #(
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 144,
  parameter int unsigned N_L0   = 144,
  parameter int unsigned N_L1   = 16,
  parameter int          THRESH = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 state,
  input  logic [5:0]           ivalid,
  input  logic signed [DW-1:0] din_0,
  input  logic signed [DW-1:0] din_1,
  input  logic signed [DW-1:0] din_2,
  input  logic signed [DW-1:0] din_3,
  input  logic signed [DW-1:0] din_4,
  input  logic signed [DW-1:0] din_5,
  input  logic                 rd_start,
  input  logic                 din_ready,
  output logic signed [DW-1:0] dout_0,
  output logic signed [DW-1:0] dout_1,
  output logic signed [DW-1:0] dout_2,
  output logic signed [DW-1:0] dout_3,
  output logic signed [DW-1:0] dout_4,
  output logic signed [DW-1:0] dout_5,
  output logic                 ovalid,
  output logic                 full,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] L0Last = CW'(N_L0 - 1);
  localparam logic [CW-1:0] L1Last = CW'(N_L1 - 1);
  localparam logic signed [DW-1:0] ThreshW = DW'(THRESH);

  typedef enum logic [1:0] {StIdle, StFill, StFull, StDrain} fsm_e;

  fsm_e          st_q, st_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          nsel_q, nsel_d;
  logic          err_q, err_d;
  logic          ovalid_q;
  logic          out_live_q;
  logic [5:0]    out_bits_q;

  logic          wr_en;
  logic          issue;
  logic          all_v;
  logic          part_v;
  logic [CW-1:0] n_last;
  logic [CW-1:0] first_last;
  logic [5:0]    din_bits;

  logic signed [DW-1:0] din_arr [6];
  logic [5:0]           mem_q [DEPTH];

  assign din_arr[0] = din_0;
  assign din_arr[1] = din_1;
  assign din_arr[2] = din_2;
  assign din_arr[3] = din_3;
  assign din_arr[4] = din_4;
  assign din_arr[5] = din_5;

  always_comb begin
    din_bits = '0;
    for (int k = 0; k < 6; k++) begin
      din_bits[k] = din_arr[k] > ThreshW;
    end
  end

  assign all_v      = &ivalid;
  assign part_v     = (|ivalid) & ~all_v;
  assign n_last     = nsel_q ? L1Last : L0Last;
  // In IDLE the frame size comes straight from the state input being latched.
  assign first_last = state ? L1Last : L0Last;

  always_comb begin
    st_d     = st_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    nsel_d   = nsel_q;
    err_d    = err_q | part_v;
    wr_en    = 1'b0;
    issue    = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (all_v) begin
          wr_en  = 1'b1;
          nsel_d = state;
          if (first_last == '0) begin
            wr_cnt_d = '0;
            st_d     = StFull;
          end else begin
            wr_cnt_d = CW'(1);
            st_d     = StFill;
          end
        end
      end
      StFill: begin
        if (all_v) begin
          wr_en = 1'b1;
          if (wr_cnt_q == n_last) begin
            wr_cnt_d = '0;
            st_d     = StFull;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      StFull: begin
        if (all_v) err_d = 1'b1;
        if (rd_start) begin
          rd_cnt_d = '0;
          st_d     = StDrain;
        end
      end
      StDrain: begin
        if (all_v) err_d = 1'b1;
        if (din_ready) begin
          issue = 1'b1;
          if (rd_cnt_q == n_last) begin
            rd_cnt_d = '0;
            st_d     = StIdle;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q       <= StIdle;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      nsel_q     <= 1'b0;
      err_q      <= 1'b0;
      ovalid_q   <= 1'b0;
      out_live_q <= 1'b0;
      out_bits_q <= '0;
    end else begin
      st_q     <= st_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      nsel_q   <= nsel_d;
      err_q    <= err_d;
      ovalid_q <= issue;
      if (issue) begin
        out_live_q <= 1'b1;
        out_bits_q <= mem_q[rd_cnt_q];
      end
    end
  end

  // Storage is not reset; its contents only matter after a complete fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_cnt_q] <= din_bits;
    end
  end

  // Output words are 0 until the first replayed word, then +1 / -1.
  function automatic logic signed [DW-1:0] to_word(input logic live, input logic b);
    if (!live) return '0;
    return b ? {{(DW-1){1'b0}}, 1'b1} : {DW{1'b1}};
  endfunction

  assign dout_0 = to_word(out_live_q, out_bits_q[0]);
  assign dout_1 = to_word(out_live_q, out_bits_q[1]);
  assign dout_2 = to_word(out_live_q, out_bits_q[2]);
  assign dout_3 = to_word(out_live_q, out_bits_q[3]);
  assign dout_4 = to_word(out_live_q, out_bits_q[4]);
  assign dout_5 = to_word(out_live_q, out_bits_q[5]);

  assign ovalid = ovalid_q;
  assign full   = (st_q == StFull);
  assign busy   = (st_q == StFill) || (st_q == StDrain);
  assign err    = err_q;

endmodule

// File: tb/tb_act_bin_buffer.sv
// Self-checking bench for act_bin_buffer: table-driven threshold frame, scoreboarded
// replay, reset, error, layer-switch and backpressure sequences.
module tb_act_bin_buffer;

  logic               clk;
  logic               rstn;
  logic               state;
  logic [5:0]         ivalid;
  logic signed [31:0] din_v [6];
  logic               rd_start;
  logic               din_ready;
  logic signed [31:0] dout_w [6];
  logic               ovalid;
  logic               full;
  logic               busy;
  logic               err;

  act_bin_buffer dut (
    .clk      (clk),
    .rstn     (rstn),
    .state    (state),
    .ivalid   (ivalid),
    .din_0    (din_v[0]),
    .din_1    (din_v[1]),
    .din_2    (din_v[2]),
    .din_3    (din_v[3]),
    .din_4    (din_v[4]),
    .din_5    (din_v[5]),
    .rd_start (rd_start),
    .din_ready(din_ready),
    .dout_0   (dout_w[0]),
    .dout_1   (dout_w[1]),
    .dout_2   (dout_w[2]),
    .dout_3   (dout_w[3]),
    .dout_4   (dout_w[4]),
    .dout_5   (dout_w[5]),
    .ovalid   (ovalid),
    .full     (full),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] din;
    logic               bitv;
  } vec_t;

  vec_t       tbl [16];
  logic [5:0] frame_bits [144];
  logic [5:0] sb [$];
  logic [5:0] last_bits;
  int         errors = 0;
  int         checks = 0;
  int         popped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic b);
    return b ? 32'h0000_0001 : 32'hFFFF_FFFF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] iv);
    ivalid = iv;
    cyc();
    ivalid = '0;
  endtask

  task automatic set_all(input logic signed [31:0] v);
    for (int k = 0; k < 6; k++) din_v[k] = v;
  endtask

  // Scoreboard consumer: every ovalid word must match the oldest issued entry.
  always @(negedge clk) begin
    if (rstn && ovalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_ovalid", 32'(ovalid), 32'd0);
      end else begin
        logic [5:0] e;
        e = sb.pop_front();
        for (int k = 0; k < 6; k++) chk("dout_lane", dout_w[k], word_of(e[k]));
        last_bits = e;
        popped++;
      end
    end
  end

  // Replays n words; toggle=1 drives din_ready 1,0,1,0,...
  task automatic drain(input int n, input bit toggle);
    int issued;
    int start_pop;
    issued    = 0;
    start_pop = popped;
    rd_start  = 1'b1;
    cyc();
    rd_start  = 1'b0;
    chk("drain_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 4 * n && issued < n; c++) begin
      din_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (din_ready) begin
        sb.push_back(frame_bits[issued]);
        issued++;
      end
      cyc();
      chk("ovalid_follows_ready", 32'(ovalid), 32'(din_ready));
      if (!ovalid) begin
        for (int k = 0; k < 6; k++) chk("dout_hold", dout_w[k], word_of(last_bits[k]));
      end
    end
    din_ready = 1'b0;
    chk("issued_count", issued, n);
    chk("busy_after_last", 32'(busy), 32'd0);
    cyc();
    chk("ovalid_after_drain", 32'(ovalid), 32'd0);
    chk("full_after_drain", 32'(full), 32'd0);
    chk("words_popped", popped - start_pop, n);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{32'sd0, 1'b0};
    tbl[1]  = '{32'sd1, 1'b1};
    tbl[2]  = '{32'sh8000_0000, 1'b0};
    tbl[3]  = '{32'sh7FFF_FFFF, 1'b1};
    tbl[4]  = '{-32'sd1, 1'b0};
    tbl[5]  = '{32'sd5, 1'b1};
    tbl[6]  = '{-32'sd3, 1'b0};
    tbl[7]  = '{32'sd2, 1'b1};
    tbl[8]  = '{32'sd0, 1'b0};
    tbl[9]  = '{32'sd100, 1'b1};
    tbl[10] = '{-32'sd100, 1'b0};
    tbl[11] = '{32'sd1, 1'b1};
    tbl[12] = '{32'sh8000_0001, 1'b0};
    tbl[13] = '{32'sd0, 1'b0};
    tbl[14] = '{32'sd3, 1'b1};
    tbl[15] = '{-32'sd2, 1'b0};

    rstn = 1'b0; state = 1'b0; ivalid = '0; rd_start = 1'b0; din_ready = 1'b0;
    last_bits = '0;
    set_all(32'sd0);
    #3;
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    for (int k = 0; k < 6; k++) chk("rst_dout", dout_w[k], 32'd0);
    cyc(); cyc();
    rstn = 1'b1;
    cyc();

    // Frame A: state switches 0->1 mid-fill, partial ivalid injected.
    for (int i = 0; i < 144; i++) begin
      if (i == 10) state = 1'b1;
      if (i == 60) begin
        chk("err_before_partial", 32'(err), 32'd0);
        set_all(32'sd9);
        put(6'b000111);
        chk("err_partial", 32'(err), 32'd1);
        chk("partial_busy", 32'(busy), 32'd1);
      end
      set_all(i[0] ? 32'sd5 : -32'sd3);
      frame_bits[i] = i[0] ? 6'h3F : 6'h00;
      put(6'h3F);
      if (i == 15) begin
        chk("switch_not_full_16", 32'(full), 32'd0);
        chk("switch_busy_16", 32'(busy), 32'd1);
      end
      if (i == 142) chk("a_not_full_143", 32'(full), 32'd0);
    end
    chk("a_full_144", 32'(full), 32'd1);
    chk("a_busy_full", 32'(busy), 32'd0);
    drain(144, 1'b0);

    // Reset mid-fill after 50 writes.
    state = 1'b0;
    for (int i = 0; i < 50; i++) begin
      set_all(32'sd7);
      put(6'h3F);
    end
    chk("mid_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_ovalid", 32'(ovalid), 32'd0);
    for (int k = 0; k < 6; k++) chk("mid_rst_dout", dout_w[k], 32'd0);
    cyc();
    rstn = 1'b1;
    cyc();

    // Frame B: per-lane pattern, then overflow writes while full.
    for (int i = 0; i < 144; i++) begin
      for (int k = 0; k < 6; k++) begin
        din_v[k] = ((i + k) % 3 == 0) ? 32'sd7 : -32'sd7;
        frame_bits[i][k] = ((i + k) % 3 == 0);
      end
      put(6'h3F);
      if (i == 142) chk("b_not_full_143", 32'(full), 32'd0);
    end
    chk("b_full_144", 32'(full), 32'd1);
    chk("b_err_clean", 32'(err), 32'd0);
    set_all(32'sd5);
    put(6'h3F);
    put(6'h3F);
    chk("overflow_err", 32'(err), 32'd1);
    chk("overflow_full", 32'(full), 32'd1);
    drain(144, 1'b0);

    // Frame C: state=1, threshold table, rd_start coincident with the last write.
    state = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 6; k++) begin
        din_v[k] = tbl[(i + k) % 16].din;
        frame_bits[i][k] = tbl[(i + k) % 16].bitv;
      end
      if (i == 15) rd_start = 1'b1;
      put(6'h3F);
      rd_start = 1'b0;
      if (i == 14) chk("c_not_full_15", 32'(full), 32'd0);
    end
    chk("c_full_16", 32'(full), 32'd1);
    cyc();
    chk("rd_start_early_ignored", 32'(full), 32'd1);
    chk("no_ovalid_in_full", 32'(ovalid), 32'd0);
    drain(16, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/act_bin_buffer.md
Name: act_bin_buffer

Overview:
- Sits directly downstream of the 6-channel conv/ReLU/maxpool stage.
- Captures each pooled output pixel of all 6 channels and binarizes it against a threshold into a 1-bit activation.
- Stores one complete pooled feature map per channel.
- On request, replays the map as signed ±1 32-bit words on 6 parallel lanes, paced by the conv stage's din_ready, as input to the next layer.

Parameters:
- DW, 32, data width of input/output words.
- DEPTH, 144, storage entries per channel; must be ≥ the larger frame size (12x12 pooled map).
- N_L0, 144, pooled pixels per channel per frame when state=0.
- N_L1, 16, pooled pixels per channel per frame when state=1.
- THRESH, 0, signed binarization threshold; bit=1 iff din > THRESH.

Ports:
- clk, input, 1, clock, rising edge.
- rstn, input, 1, asynchronous active-low reset.
- state, input, 1, layer select: 0 → frame size N_L0, 1 → N_L1; sampled on leaving IDLE.
- ivalid, input, 6, per-channel valid from pooling stage.
- din_0..din_5, input, DW signed each, pooled pixels per channel.
- rd_start, input, 1, pulse requesting a replay of the stored frame.
- din_ready, input, 1, consumer ready; one word is issued per cycle it is high during DRAIN.
- dout_0..dout_5, output, DW signed each, replayed activation: +1 for bit 1, -1 for bit 0.
- ovalid, output, 1, dout_* valid this cycle.
- full, output, 1, frame completely captured, waiting for rd_start.
- busy, output, 1, high in FILL or DRAIN.
- err, output, 1, sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, rstn=0):
  - FSM goes to IDLE; wr_cnt=0, rd_cnt=0, nsel=0.
  - dout_*=0, ovalid=0, full=0, busy=0, err=0.
  - Storage contents are don't-care.
  - Reset mid-FILL or mid-DRAIN aborts the frame immediately.
- Write acceptance: a write occurs only when ivalid==6'b111111 in IDLE or FILL.
  - Each of the 6 bits (din_k > THRESH, signed compare) is written to entry wr_cnt of channel k, and wr_cnt increments.
  - Partial ivalid (nonzero, not all ones) is dropped and sets err.
  - ivalid all ones in FULL or DRAIN is dropped and sets err (overflow).
- FSM:
  - IDLE:
    - First accepted write latches nsel=state, stores entry 0, sets wr_cnt=1, goes to FILL.
    - If that write completes the frame (N=1 edge case), goes directly to FULL.
  - FILL:
    - Accepted writes advance wr_cnt.
    - The write at wr_cnt==N-1 sets wr_cnt=0 and goes to FULL; full=1 from the next cycle.
    - A change of state while in FILL does not alter N.
  - FULL:
    - rd_start=1 goes to DRAIN with rd_cnt=0.
    - rd_start in any other state is ignored (no error).
  - DRAIN:
    - Each cycle with din_ready=1 registers entry rd_cnt of all channels onto dout_*, drives ovalid=1 in the following cycle, and increments rd_cnt.
    - Cycles with din_ready=0 give ovalid=0 next cycle; dout_* holds its last value.
    - The issue at rd_cnt==N-1 returns the FSM to IDLE (rd_cnt=0). The final word's ovalid appears in the first IDLE cycle.
- Latency: 1 cycle from din_ready sample to ovalid/dout.
- Output words: sign-extended: bit1 → 32'h00000001, bit0 → 32'hFFFFFFFF.
- N selection: N = N_L0 if nsel=0, else N_L1. Counters are sized for DEPTH; wr_cnt and rd_cnt never exceed N-1.
- Status outputs:
  - full = (FSM==FULL).
  - busy = (FSM==FILL or FSM==DRAIN).
- Simultaneous events:
  - Write on the same cycle as the FILL→FULL transition: only the N-1 write is accepted.
  - rd_start on the same cycle the FSM enters FULL is not honoured; rd_start must arrive while full=1.
- The stored frame is replayed exactly once per fill; a new frame can only start after DRAIN completes.

Test Plan:
- Reset behaviour: assert rstn=0 mid-FILL after 50 writes → all outputs 0 immediately. Then release and write 144 pixels → full=1 exactly after the 144th write.
- state=0 frame:
  - Write 144 pixels with din_k = (i odd ? 5 : -3) on every channel, then pulse rd_start and hold din_ready=1.
  - Expect 144 consecutive ovalid cycles with dout alternating -1,+1 starting at -1, on all 6 lanes.
  - Expect busy=0 after the last word.
- Threshold edge: din=THRESH=0 → stored 0 → dout=-1; din=1 → +1; din=32'h80000000 → -1.
- Backpressure: state=1, 16 pixels captured, din_ready toggling 1,0,1,0 → ovalid follows din_ready delayed 1 cycle. Exactly 16 words are issued, in order, and dout holds during gaps.
- Error paths:
  - ivalid=6'b000111 in FILL → no wr_cnt advance, err=1.
  - Writes in FULL → dropped, err=1; the stored frame replays unchanged.
- Layer switch: state changes 0→1 at pixel 10 of a frame → frame still requires 144 writes. The next frame, started with state=1, completes after 16 writes.
